// File: rtl/tms_progmem_arbiter_pkg.sv
// Shared definitions for the TMS1x00 program-memory arbiter: FSM states, owner codes, default base.
package tms_progmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam logic        OWNER_CPU = 1'b0;
    localparam logic        OWNER_WB  = 1'b1;
    localparam logic [31:0] PROG_BASE = 32'h3000_0000;

endpackage

// File: rtl/tms_progmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: req[0]=CPU, req[1]=WB; on a tie the side not granted last wins.
module rr_arbiter2
    import tms_progmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant_r;

    // One-hot grant from the current requests and the last winner
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last_grant_r == OWNER_WB) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner of every accepted grant; reset favours the CPU on the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= OWNER_WB;
        end else if (update && (grant != 2'b00)) begin
            last_grant_r <= grant[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/tms_progmem_arbiter.sv
// Shares the single-port synchronous-read program SRAM between the CPU fetch port and the Wishbone slave.
module tms_progmem_arbiter
    import tms_progmem_arbiter_pkg::*;
#(
    parameter int          ADDR_W        = 11,
    parameter logic [31:0] BASE_ADDR     = PROG_BASE,
    parameter bit          LOCK_WHEN_RUN = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              cpu_run_i,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_valid_o,
    output logic [7:0]        cpu_rdata_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              wr_viol_o
);

    state_e            state_r, next_state_s;
    logic [1:0]        req_s, grant_s;
    logic              hit_s, wb_pend_s, cpu_pend_s, lock_s, grant_any_s, wb_grant_s;
    logic              owner_r, is_write_r;
    logic              wbs_ack_r, cpu_valid_r, mem_ce_r, mem_we_r, wr_viol_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r, wb_rdata_r, cpu_rdata_r;
    logic              unused_s;

    assign unused_s    = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

    // Masking with our own ack keeps a just-finished WB cycle from being granted twice
    assign hit_s       = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign wb_pend_s   = wbs_cyc_i & wbs_stb_i & hit_s & ~wbs_ack_r;
    assign cpu_pend_s  = cpu_req_i & cpu_run_i;
    assign lock_s      = LOCK_WHEN_RUN & cpu_run_i;
    assign req_s       = {wb_pend_s, cpu_pend_s};
    assign grant_any_s = (grant_s != 2'b00);
    assign wb_grant_s  = grant_s[1];

    rr_arbiter2 u_rr (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .req    (req_s),
        .update (state_r == ST_IDLE),
        .grant  (grant_s)
    );

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_any_s) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (is_write_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CAPTURE;
                end
            end
            ST_CAPTURE: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath: latch the grant into the SRAM port, capture read data, pulse ack/valid
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            owner_r     <= OWNER_CPU;
            is_write_r  <= 1'b0;
            wbs_ack_r   <= 1'b0;
            cpu_valid_r <= 1'b0;
            mem_ce_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 8'h00;
            wb_rdata_r  <= 8'h00;
            cpu_rdata_r <= 8'h00;
            wr_viol_r   <= 1'b0;
        end else begin
            wbs_ack_r   <= 1'b0;
            cpu_valid_r <= 1'b0;
            mem_ce_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        owner_r    <= wb_grant_s;
                        is_write_r <= wb_grant_s & wbs_we_i;
                        mem_ce_r   <= 1'b1;
                        mem_we_r   <= wb_grant_s & wbs_we_i & wbs_sel_i[0] & ~lock_s;
                        if (wb_grant_s) begin
                            mem_addr_r  <= wbs_adr_i[ADDR_W+1:2];
                            mem_wdata_r <= wbs_dat_i[7:0];
                        end else begin
                            mem_addr_r  <= cpu_addr_i;
                        end
                        if (wb_grant_s & wbs_we_i & wbs_sel_i[0] & lock_s) begin
                            wr_viol_r <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (is_write_r) begin
                        wbs_ack_r <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (owner_r == OWNER_WB) begin
                        wb_rdata_r <= mem_rdata_i;
                        wbs_ack_r  <= 1'b1;
                    end else begin
                        cpu_rdata_r <= mem_rdata_i;
                        cpu_valid_r <= 1'b1;
                    end
                end
                default: begin
                    wbs_ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign wbs_ack_o   = wbs_ack_r;
    assign wbs_dat_o   = {24'h00_0000, wb_rdata_r};
    assign cpu_valid_o = cpu_valid_r;
    assign cpu_rdata_o = cpu_rdata_r;
    assign mem_ce_o    = mem_ce_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign wr_viol_o   = wr_viol_r;

endmodule
